softmax_result_reader: RTL
==========================

Name: softmax_result_reader

Overview:
- Receiving end of the softmax output write stream.
- Captures each beat marked by valid_data / sel_data (sel_data = 1..OUTPUT_SIZE) with its data word into a local buffer.
- Tracks the arg-max class while capturing.
- Once a full frame is held, drains it to a downstream consumer over a valid/ready port.

Parameters:
- DATA_WIDTH, 24, width of one softmax result word.
- OUTPUT_SIZE, 10, number of class results per frame (legal range 2..15).
- IDX_WIDTH, 4, width of sel_data and all index outputs; must satisfy 2^IDX_WIDTH > OUTPUT_SIZE.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- valid_data  in  1  write beat strobe from the softmax writer.
- sel_data  in  IDX_WIDTH  1-based class index of the current beat.
- data_in  in  DATA_WIDTH  result word; sampled only when valid_data=1.
- out_valid  out  1  drain word available.
- out_ready  in  1  downstream accepts the drain word.
- out_data  out  DATA_WIDTH  buffered word for out_idx.
- out_idx  out  IDX_WIDTH  0-based class index of out_data.
- out_last  out  1  high with the word where out_idx = OUTPUT_SIZE-1.
- argmax_idx  out  IDX_WIDTH  0-based index of the largest word of the last completed frame.
- argmax_valid  out  1  one-cycle pulse when argmax_idx updates.
- busy  out  1  high in COLLECT or DRAIN.
- err_seq  out  1  sticky sequence/overrun error flag.

Behaviour:
- Reset (async, rst=1): state=IDLE, exp_idx=1, every output 0, buffer contents don't-care, running max cleared.
- FSM states: IDLE, COLLECT, DRAIN.
- IDLE:
  - valid_data=1 with sel_data=1: store data_in at buffer[0], load the running max with {data_in, 0}, set exp_idx=2, go to COLLECT.
  - valid_data=1 with sel_data != 1: set err_seq, stay in IDLE.
- COLLECT:
  - valid_data=1 with sel_data=exp_idx: store at buffer[exp_idx-1] and increment exp_idx.
  - Max update only if data_in > running max (unsigned). A tie keeps the lower index.
  - Beat with sel_data=OUTPUT_SIZE is the last. On the next cycle: argmax_idx takes the final winner, argmax_valid=1 for exactly 1 cycle, state goes to DRAIN with drain pointer k=0.
  - Gap cycles (valid_data=0) are allowed and hold state.
  - valid_data=1 with sel_data != exp_idx: set err_seq, discard the partial frame, return to IDLE with exp_idx=1.
    - If that beat has sel_data=1, it restarts the frame instead (treated as an IDLE beat in the same cycle).
- DRAIN:
  - out_valid=1, out_data=buffer[k], out_idx=k, out_last=(k==OUTPUT_SIZE-1).
  - On out_valid&&out_ready: k increments. If out_last, go to IDLE with out_valid=0 the following cycle.
  - out_data, out_idx and out_last are held stable while out_valid=1 and out_ready=0.
  - valid_data=1 during DRAIN: beat dropped, err_seq set, drain continues unaffected.
- Latency:
  - Final capture beat to first out_valid: 1 cycle.
  - With out_ready tied to 1, a frame drains in OUTPUT_SIZE consecutive cycles.
- err_seq clears only on reset.
- Buffer: registers, OUTPUT_SIZE x DATA_WIDTH, written only in COLLECT/IDLE and read only in DRAIN. No read/write overlap, because writes are blocked in DRAIN.
- Reset mid-frame or mid-drain: immediate abort. All outputs return to reset values, and the partial frame is lost.

Optional Feature:
- Macro SOFTMAX_RD_SIGNED_CMP_EN.
  - Defined: the arg-max compare treats data_in as two's-complement signed DATA_WIDTH.
  - Undefined: unsigned compare.
- Tie rule (lower index wins) and everything else are unchanged in both modes.

Test Plan:
- Frame of 10 beats, sel 1..10, data = 100,200,...,1000, out_ready=1 -> out_data 100..1000 on consecutive cycles, out_idx 0..9, out_last only with 1000, argmax_valid pulse with argmax_idx=9.
- Same frame with data[3]=data[7]=0xFFFFFF (others small) -> argmax_idx=3 (tie keeps lower index).
- out_ready toggled 1,0,0,1,... during drain -> no word skipped or duplicated, out_data stable while stalled, 10 handshakes total.
- Beats sel 1,2,4 -> err_seq=1 after the sel=4 beat, no argmax_valid, no out_valid. Then a clean 1..10 frame drains correctly.
- valid_data pulse during DRAIN -> err_seq=1, drained words equal the original frame.
- rst asserted at drain word k=5 -> out_valid=0 and busy=0 immediately. A new frame after reset drains starting at out_idx=0.
- With SOFTMAX_RD_SIGNED_CMP_EN, data[0]=0x800000 and data[1]=0x000001 (others 0x800000) -> argmax_idx=1. Without the macro -> argmax_idx=0.

Source files
------------

// File: rtl/softmax_result_reader.sv
// Captures one softmax output frame (1-based beats), tracks its arg-max and drains it over valid/ready.
// Optional macro SOFTMAX_RD_SIGNED_CMP_EN: arg-max compare treats words as signed two's-complement.
module softmax_result_reader #(
   parameter int DATA_WIDTH  = 24,
   parameter int OUTPUT_SIZE = 10,
   parameter int IDX_WIDTH   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid_data,
   input  logic [IDX_WIDTH-1:0]  sel_data,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [IDX_WIDTH-1:0]  out_idx,
   output logic                  out_last,
   output logic [IDX_WIDTH-1:0]  argmax_idx,
   output logic                  argmax_valid,
   output logic                  busy,
   output logic                  err_seq
);

   // Drain handshake: a word transfers on every rising edge where out_valid && out_ready;
   // out_data/out_idx/out_last are held while out_valid=1 and out_ready=0.

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DRAIN   = 2'd2
   } state_t;

   localparam logic [IDX_WIDTH-1:0] ONE      = IDX_WIDTH'(1);
   localparam logic [IDX_WIDTH-1:0] TWO      = IDX_WIDTH'(2);
   localparam logic [IDX_WIDTH-1:0] LAST_SEL = IDX_WIDTH'(OUTPUT_SIZE);
   localparam logic [IDX_WIDTH-1:0] LAST_K   = IDX_WIDTH'(OUTPUT_SIZE - 1);

   state_t                state_q, state_d;
   logic [IDX_WIDTH-1:0]  exp_idx_q, exp_idx_d;
   logic [IDX_WIDTH-1:0]  k_q, k_d;
   logic [IDX_WIDTH-1:0]  max_idx_q, max_idx_d;
   logic [DATA_WIDTH-1:0] max_val_q, max_val_d;
   logic [IDX_WIDTH-1:0]  argmax_idx_q, argmax_idx_d;
   logic                  argmax_valid_q, argmax_valid_d;
   logic                  err_seq_q, err_seq_d;
   logic [DATA_WIDTH-1:0] buf_q [OUTPUT_SIZE];
   logic [DATA_WIDTH-1:0] buf_d [OUTPUT_SIZE];
   logic                  start_frame;
   logic                  beat_gt;

   // Strictly greater, so a tie keeps the earlier (lower) index.
`ifdef SOFTMAX_RD_SIGNED_CMP_EN
   assign beat_gt = $signed(data_in) > $signed(max_val_q);
`else
   assign beat_gt = data_in > max_val_q;
`endif

   always_comb begin
      state_d        = state_q;
      exp_idx_d      = exp_idx_q;
      k_d            = k_q;
      max_idx_d      = max_idx_q;
      max_val_d      = max_val_q;
      argmax_idx_d   = argmax_idx_q;
      argmax_valid_d = 1'b0;
      err_seq_d      = err_seq_q;
      buf_d          = buf_q;
      start_frame    = 1'b0;

      case (state_q)
         IDLE: begin
            if (valid_data) begin
               if (sel_data == ONE) start_frame = 1'b1;
               else                 err_seq_d   = 1'b1;
            end
         end
         COLLECT: begin
            if (valid_data) begin
               if (sel_data == exp_idx_q) begin
                  buf_d[exp_idx_q - ONE] = data_in;
                  exp_idx_d              = exp_idx_q + ONE;
                  if (beat_gt) begin
                     max_val_d = data_in;
                     max_idx_d = exp_idx_q - ONE;
                  end
                  if (sel_data == LAST_SEL) begin
                     argmax_idx_d   = beat_gt ? (exp_idx_q - ONE) : max_idx_q;
                     argmax_valid_d = 1'b1;
                     state_d        = DRAIN;
                     k_d            = '0;
                     exp_idx_d      = ONE;
                  end
               end else begin
                  err_seq_d = 1'b1;
                  // An out-of-order beat with sel=1 begins a fresh frame in the same cycle.
                  if (sel_data == ONE) begin
                     start_frame = 1'b1;
                  end else begin
                     state_d   = IDLE;
                     exp_idx_d = ONE;
                  end
               end
            end
         end
         DRAIN: begin
            if (valid_data) err_seq_d = 1'b1;
            if (out_ready) begin
               k_d = k_q + ONE;
               if (k_q == LAST_K) begin
                  state_d = IDLE;
                  k_d     = '0;
               end
            end
         end
         default: begin
            state_d   = IDLE;
            exp_idx_d = ONE;
            k_d       = '0;
         end
      endcase

      if (start_frame) begin
         buf_d[0]  = data_in;
         max_val_d = data_in;
         max_idx_d = '0;
         exp_idx_d = TWO;
         state_d   = COLLECT;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         exp_idx_q      <= ONE;
         k_q            <= '0;
         max_idx_q      <= '0;
         max_val_q      <= '0;
         argmax_idx_q   <= '0;
         argmax_valid_q <= 1'b0;
         err_seq_q      <= 1'b0;
         for (int i = 0; i < OUTPUT_SIZE; i++) buf_q[i] <= '0;
      end else begin
         state_q        <= state_d;
         exp_idx_q      <= exp_idx_d;
         k_q            <= k_d;
         max_idx_q      <= max_idx_d;
         max_val_q      <= max_val_d;
         argmax_idx_q   <= argmax_idx_d;
         argmax_valid_q <= argmax_valid_d;
         err_seq_q      <= err_seq_d;
         for (int i = 0; i < OUTPUT_SIZE; i++) buf_q[i] <= buf_d[i];
      end
   end

   // Drain outputs are forced to zero outside DRAIN so reset leaves every output at 0.
   assign out_valid    = (state_q == DRAIN);
   assign out_data     = out_valid ? buf_q[k_q] : '0;
   assign out_idx      = out_valid ? k_q : '0;
   assign out_last     = out_valid && (k_q == LAST_K);
   assign argmax_idx   = argmax_idx_q;
   assign argmax_valid = argmax_valid_q;
   assign busy         = (state_q != IDLE);
   assign err_seq      = err_seq_q;

endmodule
